// File: rtl/mem_access_unit_pkg.sv
// Shared encodings, FSM state type and alignment check for the data-memory access unit.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    // Misaligned half/word or the reserved size encoding.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: access_err = 1'b0;
            SZ_HALF: access_err = offset[0];
            SZ_WORD: access_err = (offset != 2'b00);
            default: access_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake from the MEM stage plus the word-addressed Data_Memory port.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_write_i;
    logic [1:0]        req_size_i;
    logic              req_signed_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              resp_valid_o;
    logic [DATA_W-1:0] resp_rdata_o;
    logic              resp_err_o;
    logic              busy_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    // Pipeline stage and memory together form the environment around the unit.
    modport master (
        output req_valid_i, req_write_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
        output mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o,
        input  mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
        input  mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o,
        output mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_access_unit_lane.sv
// Byte-lane datapath: little-endian load extraction with sign/zero extension and
// sub-word store merge into a previously read word.
module mem_lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = rd_word[{offset, 3'b000} +: 8];
        half_lane  = rd_word[{offset[1], 4'b0000} +: 16];
        load_data  = rd_word;
        store_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{sign_ext & byte_lane[7]}}, byte_lane};
                store_word = rd_word;
                store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data  = {{16{sign_ext & half_lane[15]}}, half_lane};
                store_word = rd_word;
                store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores via read-modify-write,
// misaligned requests answered with an error and never forwarded to memory.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_access_unit_if.slave bus
);

    state_t            state;
    logic              wr_q;
    logic              sgn_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;

    logic              req_err;
    logic [DATA_W-1:0] lane_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;

    assign req_err = access_err(bus.req_size_i, bus.req_addr_i[1:0]);

    // Loads extract straight from the memory bus in READ; merges use the captured word in WRITE.
    assign lane_word = (state == S_READ) ? bus.mem_rdata_i : data_q;

    mem_lane_unit u_lane (
        .rd_word    (lane_word),
        .offset     (addr_q[1:0]),
        .size       (size_q),
        .sign_ext   (sgn_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= S_IDLE;
            wr_q         <= 1'b0;
            sgn_q        <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        wr_q    <= bus.req_write_i;
                        sgn_q   <= bus.req_signed_i;
                        size_q  <= bus.req_size_i;
                        addr_q  <= bus.req_addr_i;
                        wdata_q <= bus.req_wdata_i;
                        if (req_err) begin
                            state        <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (bus.req_write_i && bus.req_size_i == SZ_WORD) begin
                            state <= S_WRITE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    data_q <= bus.mem_rdata_i;
                    if (wr_q) begin
                        state <= S_WRITE;
                    end else begin
                        state        <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data;
                    end
                end
                S_WRITE: begin
                    state        <= S_RESP;
                    resp_valid_q <= 1'b1;
                end
                S_RESP: begin
                    state        <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o  = (state == S_IDLE);
    assign bus.busy_o       = (state != S_IDLE);
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_err_o   = resp_err_q;
    assign bus.resp_rdata_o = resp_rdata_q;

    assign bus.mem_read_o  = (state == S_READ);
    assign bus.mem_write_o = (state == S_WRITE);
    assign bus.mem_addr_o  = (state == S_READ || state == S_WRITE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_wdata_o = (state == S_WRITE) ? store_word : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small behavioural word memory.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] mem [64];
    logic        poke_en   = 1'b0;
    logic [5:0]  poke_idx  = '0;
    logic [31:0] poke_data = '0;
    int unsigned wr_cnt    = 0;
    int unsigned rd_cnt    = 0;
    int unsigned resp_cnt  = 0;
    int unsigned n_tests   = 0;
    int unsigned n_fail    = 0;

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_data;
        else if (bus.mem_write_o) mem[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
        if (bus.mem_write_o)  wr_cnt   <= wr_cnt + 1;
        if (bus.mem_read_o)   rd_cnt   <= rd_cnt + 1;
        if (bus.resp_valid_o) resp_cnt <= resp_cnt + 1;
    end

    assign bus.mem_rdata_i = mem[bus.mem_addr_o[7:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = addr[7:2]; poke_data = data;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Returns #1 after the accept edge, i.e. early in cycle 1.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_write_i = wr; bus.req_size_i = sz;
        bus.req_signed_i = sgn; bus.req_addr_i = addr; bus.req_wdata_i = wd;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, sz, sgn, addr, 32'h0);
        @(negedge clk);
        check({tag, ".read"}, bus.mem_read_o, 1);
        check({tag, ".addr"}, bus.mem_addr_o, {addr[31:2], 2'b00});
        @(negedge clk);
        check({tag, ".valid"}, bus.resp_valid_o, 1);
        check({tag, ".rdata"}, bus.resp_rdata_o, exp);
        check({tag, ".err"}, bus.resp_err_o, 0);
    endtask

    task automatic do_substore(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] exp_word);
        issue(1'b1, sz, 1'b0, addr, wd);
        @(negedge clk);
        check({tag, ".c1_read"}, bus.mem_read_o, 1);
        check({tag, ".c1_write"}, bus.mem_write_o, 0);
        @(negedge clk);
        check({tag, ".c2_write"}, bus.mem_write_o, 1);
        check({tag, ".c2_wdata"}, bus.mem_wdata_o, exp_word);
        check({tag, ".c2_valid"}, bus.resp_valid_o, 0);
        @(negedge clk);
        check({tag, ".c3_valid"}, bus.resp_valid_o, 1);
        check({tag, ".c3_rdata"}, bus.resp_rdata_o, 0);
        check({tag, ".mem"}, mem[addr[7:2]], exp_word);
    endtask

    task automatic do_err(input string tag, input logic wr, input logic [1:0] sz, input logic [31:0] addr);
        issue(wr, sz, 1'b0, addr, 32'h1234_5678);
        @(negedge clk);
        check({tag, ".valid"}, bus.resp_valid_o, 1);
        check({tag, ".err"}, bus.resp_err_o, 1);
        check({tag, ".rdata"}, bus.resp_rdata_o, 0);
        check({tag, ".mem_rw"}, {bus.mem_read_o, bus.mem_write_o}, 0);
        @(negedge clk);
        check({tag, ".ready"}, bus.req_ready_o, 1);
    endtask

    typedef struct {
        string       tag;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t loads [9];

    initial begin
        int unsigned wc;
        int unsigned rc;
        int unsigned pc;

        loads[0] = '{"lb13",  SZ_BYTE, 1'b1, 32'h13, 32'hFFFF_FF80};
        loads[1] = '{"lbu13", SZ_BYTE, 1'b0, 32'h13, 32'h0000_0080};
        loads[2] = '{"lb11",  SZ_BYTE, 1'b1, 32'h11, 32'h0000_007F};
        loads[3] = '{"lb10",  SZ_BYTE, 1'b1, 32'h10, 32'h0000_0001};
        loads[4] = '{"lb12",  SZ_BYTE, 1'b1, 32'h12, 32'hFFFF_FFFF};
        loads[5] = '{"lh12",  SZ_HALF, 1'b1, 32'h12, 32'hFFFF_80FF};
        loads[6] = '{"lhu12", SZ_HALF, 1'b0, 32'h12, 32'h0000_80FF};
        loads[7] = '{"lh10",  SZ_HALF, 1'b1, 32'h10, 32'h0000_7F01};
        loads[8] = '{"lw10",  SZ_WORD, 1'b1, 32'h10, 32'h80FF_7F01};

        bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_size_i = 2'b00;
        bus.req_signed_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;

        repeat (2) @(negedge clk);
        check("rst.ready", bus.req_ready_o, 1);
        check("rst.busy", bus.busy_o, 0);
        check("rst.resp", {bus.resp_valid_o, bus.resp_err_o}, 0);
        check("rst.rdata", bus.resp_rdata_o, 0);
        check("rst.mem_rw", {bus.mem_read_o, bus.mem_write_o}, 0);
        check("rst.mem_addr", bus.mem_addr_o, 0);
        check("rst.mem_wdata", bus.mem_wdata_o, 0);
        rst_n = 1'b1;

        // Word store goes straight to WRITE.
        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        check("sw.c1_write", bus.mem_write_o, 1);
        check("sw.c1_read", bus.mem_read_o, 0);
        check("sw.c1_addr", bus.mem_addr_o, 32'h10);
        check("sw.c1_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
        check("sw.c1_ready", bus.req_ready_o, 0);
        check("sw.c1_busy", bus.busy_o, 1);
        @(negedge clk);
        check("sw.c2_valid", bus.resp_valid_o, 1);
        check("sw.c2_err", bus.resp_err_o, 0);
        check("sw.c2_rdata", bus.resp_rdata_o, 0);
        check("sw.c2_write", bus.mem_write_o, 0);
        @(negedge clk);
        check("sw.c3_ready", bus.req_ready_o, 1);
        check("sw.c3_valid", bus.resp_valid_o, 0);
        check("sw.mem", mem[4], 32'hDEAD_BEEF);

        poke(32'h10, 32'h80FF_7F01);
        foreach (loads[i]) do_load(loads[i].tag, loads[i].sz, loads[i].sgn, loads[i].addr, loads[i].exp);

        poke(32'h10, 32'h1122_3344);
        do_substore("sh12", SZ_HALF, 32'h12, 32'h0000_ABCD, 32'hABCD_3344);
        do_substore("sb11", SZ_BYTE, 32'h11, 32'hFFFF_FF55, 32'hABCD_5544);
        do_substore("sh10", SZ_HALF, 32'h10, 32'h0000_0102, 32'hABCD_0102);
        do_substore("sb13", SZ_BYTE, 32'h13, 32'h0000_0077, 32'h77CD_0102);

        wc = wr_cnt; rc = rd_cnt;
        do_err("lw06", 1'b0, SZ_WORD, 32'h06);
        do_err("lh01", 1'b0, SZ_HALF, 32'h01);
        do_err("rsvd", 1'b0, 2'b11, 32'h10);
        do_err("sw12", 1'b1, SZ_WORD, 32'h12);
        check("err.no_write", wr_cnt, wc);
        check("err.no_read", rd_cnt, rc);

        // Abort a sub-word store during its READ.
        wc = wr_cnt; pc = resp_cnt;
        issue(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h0000_0099);
        @(negedge clk);
        check("rmid.read", bus.mem_read_o, 1);
        rst_n = 1'b0;
        #1;
        check("rmid.ready", bus.req_ready_o, 1);
        check("rmid.busy", bus.busy_o, 0);
        check("rmid.mem_rw", {bus.mem_read_o, bus.mem_write_o}, 0);
        check("rmid.mem_addr", bus.mem_addr_o, 0);
        check("rmid.resp", {bus.resp_valid_o, bus.resp_err_o}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rmid.no_write", wr_cnt, wc);
        check("rmid.no_resp", resp_cnt, pc);
        do_load("rmid.lw", SZ_WORD, 1'b0, 32'h10, 32'h77CD_0102);

        // Valid held high across two requests.
        poke(32'h20, 32'hCAFE_1234);
        pc = resp_cnt;
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_write_i = 1'b0; bus.req_size_i = SZ_WORD;
        bus.req_signed_i = 1'b0; bus.req_addr_i = 32'h10; bus.req_wdata_i = '0;
        @(posedge clk);
        #1 bus.req_size_i = SZ_BYTE; bus.req_addr_i = 32'h22;
        @(negedge clk);
        check("b2b.c1_ready", bus.req_ready_o, 0);
        check("b2b.c1_addr", bus.mem_addr_o, 32'h10);
        @(negedge clk);
        check("b2b.c2_ready", bus.req_ready_o, 0);
        check("b2b.r1_rdata", bus.resp_rdata_o, 32'h77CD_0102);
        @(negedge clk);
        check("b2b.c3_ready", bus.req_ready_o, 1);
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("b2b.c4_ready", bus.req_ready_o, 0);
        check("b2b.c4_addr", bus.mem_addr_o, 32'h20);
        @(negedge clk);
        check("b2b.r2_valid", bus.resp_valid_o, 1);
        check("b2b.r2_rdata", bus.resp_rdata_o, 32'h0000_00FE);
        repeat (3) @(negedge clk);
        check("b2b.pulses", resp_cnt - pc, 2);
        check("b2b.idle", bus.busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
